// File: rtl/imu_sample_assembler_pkg.sv
// Shared constants and types for the IMU sample assembler: frame layout of
// the MPU6050 burst read (0x3B..0x48) and the frame-capture FSM states.
package imu_pkg;

  localparam int FRAME_BYTES = 14;
  localparam int NUM_AXES    = 6;

  // Byte offsets inside one burst frame (big-endian words, hi byte first)
  localparam int AXH = 0;
  localparam int AXL = 1;
  localparam int AYH = 2;
  localparam int AYL = 3;
  localparam int AZH = 4;
  localparam int AZL = 5;
  localparam int TH  = 6;
  localparam int TL  = 7;
  localparam int GXH = 8;
  localparam int GXL = 9;
  localparam int GYH = 10;
  localparam int GYL = 11;
  localparam int GZH = 12;
  localparam int GZL = 13;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMMIT  = 2'd2
  } state_e;

  // Hi-byte offset of axis 0..5 (AX, AY, AZ, GX, GY, GZ); temperature is skipped
  function automatic int axis_hi(input int axis);
    return (axis < 3) ? (AXH + 2 * axis) : (GXH + 2 * (axis - 3));
  endfunction

endpackage

// File: rtl/imu_sample_assembler_avg.sv
// Single-axis power-of-two moving average. A circular history of N samples
// keeps a running sum; the first push after reset (prime_i) fills the whole
// history with that sample so the first output carries no zero bias.
module imu_avg #(
  parameter int AVG_LOG2 = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic               prime_i,
  input  logic signed [15:0] sample_i,
  output logic signed [15:0] out_o
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = 16 + AVG_LOG2;

  logic signed [15:0]   hist_q [N];
  logic [AVG_LOG2-1:0]  wr_q;
  logic signed [SW-1:0] sum_q;
  logic signed [SW-1:0] sum_d;
  logic signed [SW-1:0] oldest_ext;
  logic signed [SW-1:0] sample_ext;

  assign oldest_ext = {{AVG_LOG2{hist_q[wr_q][15]}}, hist_q[wr_q]};
  assign sample_ext = {{AVG_LOG2{sample_i[15]}}, sample_i};

  // Next running sum: priming loads N copies of the sample, otherwise replace the oldest
  always_comb begin
    sum_d = sum_q;
    if (prime_i) begin
      sum_d = {sample_i, {AVG_LOG2{1'b0}}};
    end else begin
      sum_d = sum_q - oldest_ext + sample_ext;
    end
  end

  // History, write pointer and running sum update on each push
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q <= '0;
      wr_q  <= '0;
      for (int i = 0; i < N; i++) begin
        hist_q[i] <= '0;
      end
    end else if (push_i) begin
      sum_q <= sum_d;
      if (prime_i) begin
        for (int i = 0; i < N; i++) begin
          hist_q[i] <= sample_i;
        end
        wr_q <= '0;
      end else begin
        hist_q[wr_q] <= sample_i;
        wr_q         <= wr_q + AVG_LOG2'(1);
      end
    end
  end

  // Arithmetic shift floors toward minus infinity, result always fits 16 bits
  assign out_o = 16'(sum_q >>> AVG_LOG2);

endmodule

// File: rtl/imu_sample_assembler.sv
// Collects the 14-byte MPU6050 burst, splits it into six signed words,
// averages each axis and publishes held outputs two cycles after the last
// byte. Aborted, stalled or restarted frames raise a one-cycle frame_err.
module imu_sample_assembler
  import imu_pkg::*;
#(
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  input  logic               frame_abort,
  output logic signed [15:0] AX_DATA,
  output logic signed [15:0] AY_DATA,
  output logic signed [15:0] AZ_DATA,
  output logic signed [15:0] GX_DATA,
  output logic signed [15:0] GY_DATA,
  output logic signed [15:0] GZ_DATA,
  output logic               sample_valid,
  output logic               frame_err,
  output logic [7:0]         frame_cnt
);

  localparam int             TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]     IDX_LAST = 4'(FRAME_BYTES - 1);

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [7:0]         shadow_q [FRAME_BYTES];
  logic               frame_err_q, err_d;
  logic               pub_q;
  logic               sample_valid_q;
  logic [7:0]         frame_cnt_q;
  logic               primed_q;
  logic signed [15:0] data_q  [NUM_AXES];
  logic signed [15:0] raw     [NUM_AXES];
  logic signed [15:0] avg_out [NUM_AXES];

  logic               in_collect;
  logic               timeout_hit;
  logic               kill;
  logic               take_byte;
  logic               wr_en;
  logic [3:0]         wr_idx;
  logic               push;

  // Event decode: a kill (abort or stall) always beats a byte on the same cycle
  assign in_collect  = (state_q == S_COLLECT);
  assign timeout_hit = in_collect && !byte_valid && (timer_q == TMO_LAST);
  assign kill        = in_collect && (frame_abort || timeout_hit);
  assign take_byte   = byte_valid && !kill && (frame_start || in_collect);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: frame_start restarts from any state, even after a kill
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = S_COLLECT;
    end else if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_IDLE;
        S_COLLECT: if (take_byte && (idx_q == IDX_LAST)) state_d = S_COMMIT;
        S_COMMIT:  state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: shadow write control, byte index, idle timer and error pulse
  always_comb begin
    push   = (state_q == S_COMMIT);
    err_d  = in_collect && (kill || frame_start);
    wr_en  = take_byte;
    wr_idx = frame_start ? 4'd0 : idx_q;
    if (frame_start) begin
      idx_d = take_byte ? 4'd1 : 4'd0;
    end else if (take_byte) begin
      idx_d = idx_q + 4'd1;
    end else begin
      idx_d = idx_q;
    end
    if (frame_start || take_byte || kill || !in_collect) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Frame bookkeeping registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q       <= '0;
      timer_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      frame_err_q <= err_d;
    end
  end

  // Shadow byte buffer; contents are meaningless until a frame completes
  always_ff @(posedge clk) begin
    if (wr_en) begin
      shadow_q[wr_idx] <= byte_data;
    end
  end

  // One averager per axis, fed with big-endian words from the shadow buffer
  for (genvar gi = 0; gi < NUM_AXES; gi++) begin : g_axis
    localparam int HI = axis_hi(gi);
    assign raw[gi] = {shadow_q[4'(HI)], shadow_q[4'(HI + 1)]};
    imu_avg #(
      .AVG_LOG2(AVG_LOG2)
    ) u_avg (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .prime_i (!primed_q),
      .sample_i(raw[gi]),
      .out_o   (avg_out[gi])
    );
  end

  // Publish stage: averager settles one cycle after COMMIT, outputs latch the next
  always_ff @(posedge clk) begin
    if (!reset) begin
      pub_q          <= 1'b0;
      sample_valid_q <= 1'b0;
      frame_cnt_q    <= '0;
      primed_q       <= 1'b0;
      for (int i = 0; i < NUM_AXES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      pub_q          <= push;
      sample_valid_q <= pub_q;
      if (push) begin
        primed_q <= 1'b1;
      end
      if (pub_q) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
        for (int i = 0; i < NUM_AXES; i++) begin
          data_q[i] <= avg_out[i];
        end
      end
    end
  end

  assign AX_DATA      = data_q[0];
  assign AY_DATA      = data_q[1];
  assign AZ_DATA      = data_q[2];
  assign GX_DATA      = data_q[3];
  assign GY_DATA      = data_q[4];
  assign GZ_DATA      = data_q[5];
  assign sample_valid = sample_valid_q;
  assign frame_err    = frame_err_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_imu_sample_assembler.sv
// Directed bench for imu_sample_assembler with AVG_LOG2=2, TIMEOUT_CYC=100.
// Expected values are hand-computed from the averaging rules.
module tb_imu_sample_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_abort;
  logic [15:0] ax, ay, az, gx, gy, gz;
  logic        sample_valid;
  logic        frame_err;
  logic [7:0]  frame_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          errs;
  logic [7:0]  fb [14];

  always #10 clk = ~clk;

  imu_sample_assembler #(
    .AVG_LOG2   (2),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .frame_abort (frame_abort),
    .AX_DATA     (ax),
    .AY_DATA     (ay),
    .AZ_DATA     (az),
    .GX_DATA     (gx),
    .GY_DATA     (gy),
    .GZ_DATA     (gz),
    .sample_valid(sample_valid),
    .frame_err   (frame_err),
    .frame_cnt   (frame_cnt)
  );

  function automatic logic [31:0] w16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return {16'h0, t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_frame(input int a, input int b, input int c,
                            input int d, input int e, input int f);
    logic [15:0] w [6];
    w[0] = a[15:0]; w[1] = b[15:0]; w[2] = c[15:0];
    w[3] = d[15:0]; w[4] = e[15:0]; w[5] = f[15:0];
    for (int i = 0; i < 3; i++) begin
      fb[2*i]     = w[i][15:8];
      fb[2*i+1]   = w[i][7:0];
      fb[8+2*i]   = w[3+i][15:8];
      fb[8+2*i+1] = w[3+i][7:0];
    end
    fb[6] = 8'hA5;
    fb[7] = 8'h5A;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic send_bytes(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      byte_valid = 1'b1;
      byte_data  = fb[i];
      step();
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_outs(input string tag, input int a, input int b, input int c,
                            input int d, input int e, input int f, input int cnt);
    chk({tag, "_ax"}, {16'h0, ax}, w16(a));
    chk({tag, "_ay"}, {16'h0, ay}, w16(b));
    chk({tag, "_az"}, {16'h0, az}, w16(c));
    chk({tag, "_gx"}, {16'h0, gx}, w16(d));
    chk({tag, "_gy"}, {16'h0, gy}, w16(e));
    chk({tag, "_gz"}, {16'h0, gz}, w16(f));
    chk({tag, "_cnt"}, {24'h0, frame_cnt}, cnt);
  endtask

  // Called right after the edge that accepted byte 13
  task automatic expect_sample(input string tag, input int a, input int b, input int c,
                               input int d, input int e, input int f, input int cnt);
    step();
    chk({tag, "_sv_early"}, {31'h0, sample_valid}, 0);
    step();
    chk({tag, "_sv"}, {31'h0, sample_valid}, 1);
    check_outs(tag, a, b, c, d, e, f, cnt);
    $display("sample %s: AX=%0d AY=%0d AZ=%0d GX=%0d GY=%0d GZ=%0d cnt=%0d",
             tag, $signed(ax), $signed(ay), $signed(az),
             $signed(gx), $signed(gy), $signed(gz), frame_cnt);
    step();
    chk({tag, "_sv_drop"}, {31'h0, sample_valid}, 0);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (sample_valid) pulses++;
    end
    chk(tag, pulses, 0);
  endtask

  initial begin
    reset       = 1'b0;
    frame_start = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
    frame_abort = 1'b0;
    repeat (3) step();
    check_outs("rst", 0, 0, 0, 0, 0, 0, 0);
    chk("rst_sv", {31'h0, sample_valid}, 0);
    chk("rst_err", {31'h0, frame_err}, 0);
    reset = 1'b1;
    step();

    // First frame primes: outputs equal raw words
    load_frame('h1234, 'hFF00, 'h2000, 1, -1, 0);
    start_frame();
    send_bytes(0, 13);
    expect_sample("first", 'h1234, 'hFF00, 'h2000, 1, -1, 0, 1);
    start_frame();
    send_bytes(0, 13);
    expect_sample("repeat", 'h1234, 'hFF00, 'h2000, 1, -1, 0, 2);

    // Reset mid-COLLECT clears everything
    start_frame();
    send_bytes(0, 2);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_outs("midrst", 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_sv", {31'h0, sample_valid}, 0);

    // Next frame re-primes
    load_frame(0, -500, 0, 0, 0, 0);
    start_frame();
    send_bytes(0, 13);
    expect_sample("reprime", 0, -500, 0, 0, 0, 0, 1);

    // Abort after byte 7
    load_frame('h1111, 'h1111, 'h1111, 'h1111, 'h1111, 'h1111);
    start_frame();
    send_bytes(0, 7);
    frame_abort = 1'b1;
    step();
    frame_abort = 1'b0;
    chk("abort_err", {31'h0, frame_err}, 1);
    chk("abort_sv", {31'h0, sample_valid}, 0);
    step();
    chk("abort_err_clr", {31'h0, frame_err}, 0);
    expect_quiet("abort_quiet", 3);
    check_outs("abort_hold", 0, -500, 0, 0, 0, 0, 1);
    load_frame(0, -100, 0, 0, 0, 0);
    start_frame();
    send_bytes(0, 13);
    expect_sample("after_abort", 0, -400, 0, 0, 0, 0, 2);

    // Abort together with byte 13: byte dropped, no sample
    load_frame('h2222, 'h2222, 'h2222, 'h2222, 'h2222, 'h2222);
    start_frame();
    send_bytes(0, 12);
    byte_valid  = 1'b1;
    byte_data   = fb[13];
    frame_abort = 1'b1;
    step();
    byte_valid  = 1'b0;
    frame_abort = 1'b0;
    chk("abort13_err", {31'h0, frame_err}, 1);
    expect_quiet("abort13_quiet", 4);
    check_outs("abort13_hold", 0, -400, 0, 0, 0, 0, 2);

    // 99-cycle stall completes normally
    load_frame(0, 300, 0, 0, 0, 0);
    start_frame();
    send_bytes(0, 5);
    errs = 0;
    repeat (99) begin
      step();
      if (frame_err) errs++;
    end
    chk("stall99_err", errs, 0);
    send_bytes(6, 13);
    expect_sample("stall99", 0, -200, 0, 0, 0, 0, 3);

    // 100-cycle stall times out; late bytes ignored in IDLE
    start_frame();
    send_bytes(0, 5);
    errs = 0;
    repeat (99) begin
      step();
      if (frame_err) errs++;
    end
    chk("tmo_early", errs, 0);
    step();
    chk("tmo_err", {31'h0, frame_err}, 1);
    send_bytes(6, 13);
    expect_quiet("tmo_quiet", 3);
    check_outs("tmo_hold", 0, -200, 0, 0, 0, 0, 3);

    // frame_start with byte at idx 9 restarts; that byte is the new AX hi
    load_frame('h7777, 'h7777, 'h7777, 'h7777, 'h7777, 'h7777);
    start_frame();
    send_bytes(0, 8);
    load_frame('h4000, -200, 0, 0, 0, 0);
    frame_start = 1'b1;
    byte_valid  = 1'b1;
    byte_data   = fb[0];
    step();
    frame_start = 1'b0;
    byte_valid  = 1'b0;
    chk("restart_err", {31'h0, frame_err}, 1);
    send_bytes(1, 13);
    expect_sample("restart", 'h1000, -125, 0, 0, 0, 0, 4);

    // Averaging sequence from a fresh prime
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    load_frame(-3, 100, 4000, 7, -1, 0);
    start_frame();
    send_bytes(0, 13);
    expect_sample("avg1", -3, 100, 4000, 7, -1, 0, 1);
    load_frame(0, 100, 8000, 0, -1, 0);
    start_frame();
    send_bytes(0, 13);
    expect_sample("avg2", -3, 100, 5000, 5, -1, 0, 2);
    start_frame();
    send_bytes(0, 13);
    expect_sample("avg3", -2, 100, 6000, 3, -1, 0, 3);
    start_frame();
    send_bytes(0, 13);
    expect_sample("avg4", -1, 100, 7000, 1, -1, 0, 4);
    start_frame();
    send_bytes(0, 13);
    expect_sample("avg5", 0, 100, 8000, 0, -1, 0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
